// File: rtl/h2bp_pkg.sv
// Shared h2bp types and constants used by the loadable instruction memory.
package h2bp_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    LOAD = 1'b1
  } imem_state_t;

  typedef enum logic {
    IMEM_ADDR_WORD = 1'b0,
    IMEM_ADDR_BYTE = 1'b1
  } imem_addr_mode_t;

  localparam logic [31:0] IMEM_NOP = 32'h0000_0000;

endpackage

// File: rtl/imem_ram.sv
// DEPTH x XLEN instruction RAM: one synchronous write port, one synchronous
// read port with read-enable. Read data holds while re is low.
module imem_ram #(
  parameter int DEPTH = 256,
  parameter int XLEN  = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic            re,
  input  logic [AW-1:0]   raddr,
  output logic [XLEN-1:0] rdata
);

  logic [XLEN-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/imem_prog.sv
// Run-time loadable instruction memory: streaming load port plus a
// one-cycle-latency fetch port with stall hold and range/alignment faults.
//
// state | meaning
// RUN   | fetches accepted, load port idle (load_ready=0)
// LOAD  | load port accepts one word per cycle, fetches ignored
module imem_prog
  import h2bp_pkg::*;
#(
  parameter int              DEPTH     = 256,
  parameter int              XLEN      = 32,
  parameter imem_addr_mode_t ADDR_MODE = IMEM_ADDR_WORD
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_start,
  input  logic            load_valid,
  input  logic [XLEN-1:0] load_data,
  input  logic            load_last,
  output logic            load_ready,
  output logic            load_done,
  input  logic            fetch_req,
  input  logic            fetch_stall,
  input  logic [31:0]     pc,
  output logic [XLEN-1:0] instr,
  output logic            instr_valid,
  output logic            fault
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  imem_state_t     state_q, state_d;
  logic [AW-1:0]   wptr_q;
  logic [CW-1:0]   load_count_q;
  logic            load_done_q, instr_valid_q, fault_q, use_mem_q;
  logic            wr_en, wr_final, fetch_acc, misalign, out_of_range, unprog;
  logic [31:0]     idx;
  logic [XLEN-1:0] rdata;

  always_comb begin
    idx          = (ADDR_MODE == IMEM_ADDR_BYTE) ? {2'b00, pc[31:2]} : pc;
    misalign     = (ADDR_MODE == IMEM_ADDR_BYTE) && (pc[1:0] != 2'b00);
    out_of_range = idx >= 32'(DEPTH);
    unprog       = idx >= 32'(load_count_q);
    // a restart pulse takes the cycle; any word presented with it is dropped
    wr_en        = (state_q == LOAD) && load_valid && !load_start;
    wr_final     = load_last || (wptr_q == AW'(DEPTH - 1));
    fetch_acc    = (state_q == RUN) && !load_start && fetch_req && !fetch_stall;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (load_start) state_d = LOAD;
      LOAD:    if (wr_en && wr_final) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RUN;
      wptr_q       <= '0;
      load_count_q <= '0;
      load_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      load_done_q <= wr_en && wr_final;
      if (load_start) begin
        wptr_q       <= '0;
        load_count_q <= '0;
      end else if (wr_en) begin
        wptr_q <= wptr_q + 1'b1;
        if (wr_final) load_count_q <= CW'(wptr_q) + CW'(1);
      end
    end
  end

  // instr is muxed from the held RAM read data, so only the select is stored
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_valid_q <= 1'b0;
      fault_q       <= 1'b0;
      use_mem_q     <= 1'b0;
    end else if (!fetch_stall) begin
      instr_valid_q <= fetch_acc;
      if (fetch_acc) begin
        fault_q   <= misalign || out_of_range;
        use_mem_q <= !(misalign || out_of_range || unprog);
      end
    end
  end

  imem_ram #(
    .DEPTH (DEPTH),
    .XLEN  (XLEN),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wptr_q),
    .wdata (load_data),
    .re    (fetch_acc),
    .raddr (idx[AW-1:0]),
    .rdata (rdata)
  );

  assign load_ready  = (state_q == LOAD);
  assign load_done   = load_done_q;
  assign instr       = use_mem_q ? rdata : XLEN'(IMEM_NOP);
  assign instr_valid = instr_valid_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_imem_prog.sv
// Directed bench for imem_prog: word- and byte-mode instances share stimulus.
module tb_imem_prog;
  import h2bp_pkg::*;

  localparam int DEPTH = 8;
  localparam int XLEN  = 32;

  logic            clk = 1'b0;
  logic            rst, load_start, load_valid, load_last, fetch_req, fetch_stall;
  logic [XLEN-1:0] load_data;
  logic [31:0]     pc;

  logic            lr_w, ld_w, iv_w, f_w;
  logic [XLEN-1:0] instr_w;
  logic            lr_b, ld_b, iv_b, f_b;
  logic [XLEN-1:0] instr_b;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  imem_prog #(.DEPTH(DEPTH), .XLEN(XLEN), .ADDR_MODE(IMEM_ADDR_WORD)) u_w (
    .clk(clk), .rst(rst), .load_start(load_start), .load_valid(load_valid),
    .load_data(load_data), .load_last(load_last), .load_ready(lr_w),
    .load_done(ld_w), .fetch_req(fetch_req), .fetch_stall(fetch_stall),
    .pc(pc), .instr(instr_w), .instr_valid(iv_w), .fault(f_w));

  imem_prog #(.DEPTH(DEPTH), .XLEN(XLEN), .ADDR_MODE(IMEM_ADDR_BYTE)) u_b (
    .clk(clk), .rst(rst), .load_start(load_start), .load_valid(load_valid),
    .load_data(load_data), .load_last(load_last), .load_ready(lr_b),
    .load_done(ld_b), .fetch_req(fetch_req), .fetch_stall(fetch_stall),
    .pc(pc), .instr(instr_b), .instr_valid(iv_b), .fault(f_b));

  always @(negedge clk) if (ld_w === 1'b1) done_cnt++;

  typedef struct {
    logic        byte_dut;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
    logic        fault;
  } vec_t;

  vec_t vecs[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic apply_vecs(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      fetch_req = 1'b1;
      pc        = vecs[i].pc;
      tick();
      if (vecs[i].byte_dut) begin
        chk($sformatf("v%0d byte instr", i), instr_b, vecs[i].instr);
        chk($sformatf("v%0d byte valid", i), 32'(iv_b), 32'(vecs[i].valid));
        chk($sformatf("v%0d byte fault", i), 32'(f_b), 32'(vecs[i].fault));
      end else begin
        chk($sformatf("v%0d word instr", i), instr_w, vecs[i].instr);
        chk($sformatf("v%0d word valid", i), 32'(iv_w), 32'(vecs[i].valid));
        chk($sformatf("v%0d word fault", i), 32'(f_w), 32'(vecs[i].fault));
      end
    end
    fetch_req = 1'b0;
  endtask

  task automatic load_words(input logic [31:0] base, input int n);
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    chk("load_ready in LOAD", 32'(lr_w), 32'd1);
    for (int i = 0; i < n; i++) begin
      load_valid = 1'b1;
      load_data  = base + 32'(i);
      load_last  = (i == n - 1);
      tick();
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  initial begin
    int accepted;
    int done_before;

    // 0-2: empty memory; 3-11: three-word program; 12-14: overflow load; 15-17: reload
    vecs.push_back('{1'b0, 32'd0,  32'h0000_0000, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 32'd1,  32'h0000_0000, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 32'd2,  32'h0000_0000, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 32'd0,  32'h0841_5555, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 32'd1,  32'h08C1_5555, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 32'd2,  32'h8046_000E, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 32'd3,  32'h0000_0000, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 32'd8,  32'h0000_0000, 1'b1, 1'b1});
    vecs.push_back('{1'b1, 32'd8,  32'h8046_000E, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 32'd6,  32'h0000_0000, 1'b1, 1'b1});
    vecs.push_back('{1'b1, 32'd32, 32'h0000_0000, 1'b1, 1'b1});
    vecs.push_back('{1'b1, 32'd4,  32'h08C1_5555, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 32'd7,  32'hA000_0007, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 32'd0,  32'hA000_0000, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 32'd8,  32'h0000_0000, 1'b1, 1'b1});
    vecs.push_back('{1'b0, 32'd0,  32'hC000_0000, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 32'd2,  32'hC000_0002, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 32'd3,  32'h0000_0000, 1'b1, 1'b0});

    rst = 1'b1; load_start = 1'b0; load_valid = 1'b0; load_last = 1'b0;
    load_data = '0; fetch_req = 1'b0; fetch_stall = 1'b0; pc = '0;
    tick();
    tick();
    chk("rst load_ready", 32'(lr_w), 32'd0);
    chk("rst load_done", 32'(ld_w), 32'd0);
    chk("rst instr", instr_w, 32'h0);
    chk("rst instr_valid", 32'(iv_w), 32'd0);
    chk("rst fault", 32'(f_w), 32'd0);
    chk("rst byte valid", 32'(iv_b), 32'd0);
    chk("rst byte load_ready", 32'(lr_b), 32'd0);
    rst = 1'b0;
    tick();

    apply_vecs(0, 2);

    // valid drops the cycle after load_start; done pulses once, fetch in the done cycle
    done_before = done_cnt;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    chk("valid drop on load", 32'(iv_w), 32'd0);
    chk("load_ready in LOAD", 32'(lr_w), 32'd1);
    load_data = 32'h0841_5555; load_valid = 1'b1; tick();
    load_data = 32'h08C1_5555; tick();
    load_data = 32'h8046_000E; load_last = 1'b1; tick();
    load_valid = 1'b0; load_last = 1'b0;
    chk("load_done pulse", 32'(ld_w), 32'd1);
    chk("load_ready after last", 32'(lr_w), 32'd0);
    apply_vecs(3, 11);
    chk("load_done count", 32'(done_cnt - done_before), 32'd1);

    // stall hold: a request during the stall must not replace instr
    fetch_req = 1'b1; pc = 32'd1;
    tick();
    chk("pre-stall instr", instr_w, 32'h08C1_5555);
    fetch_stall = 1'b1; pc = 32'd2;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("stall%0d instr", i), instr_w, 32'h08C1_5555);
      chk($sformatf("stall%0d valid", i), 32'(iv_w), 32'd1);
    end
    fetch_stall = 1'b0; fetch_req = 1'b0;
    tick();
    chk("post-stall valid", 32'(iv_w), 32'd0);
    chk("post-stall instr hold", instr_w, 32'h08C1_5555);

    // overflow: DEPTH+2 words, no load_last
    done_before = done_cnt;
    accepted = 0;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      load_valid = 1'b1;
      load_data  = 32'hA000_0000 + 32'(i);
      if (lr_w) accepted++;
      tick();
    end
    load_valid = 1'b0;
    chk("overflow accepted", 32'(accepted), 32'(DEPTH));
    chk("overflow load_ready", 32'(lr_w), 32'd0);
    chk("overflow done count", 32'(done_cnt - done_before), 32'd1);
    apply_vecs(12, 14);

    // reset mid-load aborts; memory reads as NOP until a full reload
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    load_valid = 1'b1;
    load_data = 32'hB000_0000; tick();
    load_data = 32'hB000_0001; tick();
    load_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort load_ready", 32'(lr_w), 32'd0);
    fetch_req = 1'b1; pc = 32'd0;
    tick();
    fetch_req = 1'b0;
    chk("abort fetch instr", instr_w, 32'h0);
    chk("abort fetch valid", 32'(iv_w), 32'd1);
    chk("abort fetch fault", 32'(f_w), 32'd0);
    load_words(32'hC000_0000, 3);
    chk("reload done", 32'(ld_w), 32'd1);
    apply_vecs(15, 17);

    tick();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/imem_prog.md
# imem_prog

Parametrised, run-time loadable instruction memory for the h2bp core. It replaces the fixed instruction table with a synchronous RAM filled through a streaming load port. The fetch port supports a request/stall handshake, and it can use word or byte addressing. It sits between the fetch stage (pc in, instruction out) and the boot/debug loader.

## Interface
Parameters:
- DEPTH, 256, number of instruction words; power of two, ≥ 4.
- XLEN, 32, instruction width in bits.
- ADDR_MODE, IMEM_ADDR_WORD, IMEM_ADDR_WORD: the pc is a word index. IMEM_ADDR_BYTE: the pc is a byte address and the index is pc[31:2].

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset; synchronous, active-high.
- load_start  in  1  pulse; begins a program load at word 0.
- load_valid  in  1  load_data is valid this cycle.
- load_data  in  XLEN  instruction word to write.
- load_last  in  1  qualifies load_valid; marks the final word of the load.
- load_ready  out  1  the block accepts a load word this cycle.
- load_done  out  1  one-cycle pulse when a load completes.
- fetch_req  in  1  fetch request for pc.
- fetch_stall  in  1  the downstream stage holds; output is frozen.
- pc  in  32  fetch address.
- instr  out  XLEN  fetched instruction.
- instr_valid  out  1  instr holds a completed fetch.
- fault  out  1  the fetch in instr was misaligned or out of range.

## Operation
- FSM states: RUN and LOAD. After reset the state is RUN.
- Reset values: load_ready=0, load_done=0, instr=0, instr_valid=0, fault=0.
- Reset clears the write pointer wptr=0 and the programmed word count load_count=0. The RAM contents are not cleared.
- RUN → LOAD on load_start. On entry, wptr=0 and load_count=0.
- load_start while already in LOAD restarts the load: wptr=0.
- In LOAD, load_ready=1. Each cycle with load_valid=1 writes mem[wptr]=load_data and increments wptr.
- LOAD → RUN when the accepted word has load_last=1 or wptr==DEPTH-1.
  - On this transition, load_count=wptr+1.
  - load_done pulses in the cycle after the final write.
  - Words after DEPTH words are not accepted, because load_ready=0 in RUN.
- Index calculation: idx = pc in word mode; idx = pc[31:2] in byte mode.
- Fetches are accepted only in RUN, when fetch_req=1 and fetch_stall=0.
- Result of an accepted fetch, in priority order:
  - Byte mode with pc[1:0]≠0: instr=IMEM_NOP, fault=1.
  - idx ≥ DEPTH: instr=IMEM_NOP, fault=1.
  - idx ≥ load_count (unprogrammed word): instr=IMEM_NOP, fault=0.
  - Otherwise: instr=mem[idx], fault=0.
- Output register behaviour:
  - fetch_stall=1: instr, instr_valid and fault hold their values.
  - No stall and no accepted fetch: instr_valid=0 and instr holds its value.
- LOAD has priority over fetch:
  - fetch_req is ignored in any cycle where load_start=1 or the state is LOAD.
  - When no stall is applied, instr_valid drops to 0 in the cycle after load_start.
- Reset mid-load aborts the load. The state returns to RUN with load_count=0, so every fetch returns IMEM_NOP until a new load completes.

## Timing
- Fetch latency is 1 cycle: a request accepted at edge N is presented on instr/instr_valid/fault after edge N.
- Back-to-back fetches sustain one instruction per cycle.
- A load write at edge N is visible to a fetch accepted at edge N+1 or later. This holds once the block is back in RUN.
- load_done rises in the cycle after the last write. The first fetch can be accepted in that same cycle.
- Load throughput is one word per cycle. There is no back-pressure inside LOAD.

## Structure
- Shared h2bp package holds:
  - imem_state_t (RUN, LOAD).
  - imem_addr_mode_t (IMEM_ADDR_WORD, IMEM_ADDR_BYTE).
  - IMEM_NOP = 32'h0000_0000.
- Sub-module imem_ram: DEPTH×XLEN array with one synchronous write port, one synchronous read port and a read-enable. It has no reset.
- imem_prog contains the FSM, wptr, load_count, address decode, fault logic and the output/stall register.

## Test plan
- Reset, then fetch with pc=0,1,2 → instr=0 on every fetch, instr_valid=1 one cycle after each request, fault=0.
- Load the three words 0x08415555, 0x08C15555, 0x8046000E, with load_last on the third, then fetch pc=0,1,2,3 back-to-back:
  - Expected instr: 0x08415555, 0x08C15555, 0x8046000E, 0x00000000.
  - load_done pulses once.
- ADDR_MODE=IMEM_ADDR_BYTE with the same program:
  - pc=8 → 0x8046000E.
  - pc=6 → instr=0, fault=1.
  - pc=4·DEPTH → fault=1.
- Assert fetch_stall for 3 cycles right after a fetch of pc=1 → instr stays 0x08C15555 with instr_valid=1. A request made during the stall is not accepted.
- Stream DEPTH+2 words without load_last → exactly DEPTH words are written, then load_ready=0 and load_done pulses. Fetch of idx DEPTH-1 returns the last accepted word.
- Assert rst after 2 of 3 load words → state returns to RUN, fetch of pc=0 returns 0, then a full reload succeeds.
